// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and the load/store port.
// D-side wins by default; a bounded D streak guarantees fetch progress; stalled accesses time out.
module mem_arbiter #(
  parameter int unsigned AW           = 32,
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [31:0]   i_rd,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wd,
  input  logic [3:0]    d_be,
  output logic          d_ack,
  output logic [31:0]   d_rd,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wd,
  output logic [3:0]    mem_be,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rd,
  output logic          bus_err
);

  localparam int unsigned SW = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
  localparam int unsigned TW = 8;
  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            owner_d_q, owner_d_d;
  logic [SW-1:0]   streak_q, streak_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wd_q, mem_wd_d;
  logic [3:0]      mem_be_q, mem_be_d;
  logic            i_ack_q, i_ack_d;
  logic            d_ack_q, d_ack_d;
  logic [31:0]     i_rd_q, i_rd_d;
  logic [31:0]     d_rd_q, d_rd_d;
  logic            bus_err_q, bus_err_d;
  logic            grant_d_c;
  logic            streak_full_c;
  logic            timeout_c;
  logic [31:0]     rdata_c;

  assign streak_full_c = (streak_q == SW'(MAX_D_STREAK));
  assign grant_d_c     = d_req && !(i_req && streak_full_c);
  assign timeout_c     = (tcnt_q == TW'(TIMEOUT));

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    owner_d_d  = owner_d_q;
    streak_d   = streak_q;
    tcnt_d     = tcnt_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_wd_d   = mem_wd_q;
    mem_be_d   = mem_be_q;
    i_rd_d     = i_rd_q;
    d_rd_d     = d_rd_q;
    i_ack_d    = 1'b0;
    d_ack_d    = 1'b0;
    bus_err_d  = 1'b0;
    rdata_c    = mem_ack ? mem_rd : ERR_DATA;

    case (state_q)
      S_IDLE: begin
        if (grant_d_c) begin
          owner_d_d  = 1'b1;
          mem_req_d  = 1'b1;
          mem_we_d   = d_we;
          mem_addr_d = d_addr;
          mem_wd_d   = d_wd;
          mem_be_d   = d_we ? d_be : 4'hF;
          state_d    = S_WAIT;
          // The streak only grows while fetch is actually being held off
          if (!i_req)              streak_d = '0;
          else if (!streak_full_c) streak_d = streak_q + SW'(1);
        end else if (i_req) begin
          owner_d_d  = 1'b0;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = i_addr;
          mem_wd_d   = '0;
          mem_be_d   = 4'hF;
          streak_d   = '0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_ack || timeout_c) begin
          mem_req_d = 1'b0;
          tcnt_d    = '0;
          bus_err_d = !mem_ack;
          state_d   = S_DONE;
          if (owner_d_q) begin
            d_ack_d = 1'b1;
            if (!mem_we_q) d_rd_d = rdata_c;
          end else begin
            i_ack_d = 1'b1;
            i_rd_d  = rdata_c;
          end
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      owner_d_q  <= 1'b0;
      streak_q   <= '0;
      tcnt_q     <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_wd_q   <= '0;
      mem_be_q   <= '0;
      i_ack_q    <= 1'b0;
      d_ack_q    <= 1'b0;
      i_rd_q     <= '0;
      d_rd_q     <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_d_q  <= owner_d_d;
      streak_q   <= streak_d;
      tcnt_q     <= tcnt_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
      mem_be_q   <= mem_be_d;
      i_ack_q    <= i_ack_d;
      d_ack_q    <= d_ack_d;
      i_rd_q     <= i_rd_d;
      d_rd_q     <= d_rd_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wd   = mem_wd_q;
  assign mem_be   = mem_be_q;
  assign i_ack    = i_ack_q;
  assign d_ack    = d_ack_q;
  assign i_rd     = i_rd_q;
  assign d_rd     = d_rd_q;
  assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model of grants, completions and read data,
// driven by directed scenarios followed by a randomized request/latency phase.
module tb_mem_arbiter;

  localparam int unsigned AW      = 32;
  localparam int          MAXS    = 4;
  localparam int          TIMEOUT = 255;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, d_req, d_we, mem_ack;
  logic [AW-1:0] i_addr, d_addr;
  logic [31:0]   d_wd, mem_rd;
  logic [3:0]    d_be;
  logic          i_ack, d_ack, mem_req, mem_we, bus_err;
  logic [31:0]   i_rd, d_rd, mem_wd;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;

  mem_arbiter #(.AW(AW), .MAX_D_STREAK(MAXS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rd(i_rd),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wd(d_wd), .d_be(d_be),
    .d_ack(d_ack), .d_rd(d_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rd(mem_rd), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Transaction-level model of the arbiter
  typedef enum logic [1:0] {M_IDLE, M_WAIT, M_DONE} mph_e;
  mph_e        ph = M_IDLE;
  bit          own_d = 1'b0;
  logic        exp_we = 1'b0;
  logic [31:0] exp_addr = '0, exp_wd = '0;
  logic [3:0]  exp_be = '0;
  bit          exp_err = 1'b0;
  int          wcnt = 0, streak = 0, lat = 0;
  logic [31:0] m_i_rd = '0, m_d_rd = '0;
  int          m_done = 0, m_errs = 0;
  logic [31:0] mem [logic [29:0]];
  bit          glog[$];
  int          cyc_n = 0, n_iack = 0, n_dack = 0, n_err = 0, req_high = 0;
  bit          auto_mode = 1'b0, renew_mode = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, want, cyc_n);
    end
  endtask

  function automatic logic [31:0] rdmem(input logic [31:0] a);
    logic [29:0] w;
    w = a[31:2];
    if (mem.exists(w)) return mem[w];
    return (a & 32'hFFFF_FFFC) ^ 32'hA5C3_0F96;
  endfunction

  task automatic new_i();
    i_req  = 1'b1;
    i_addr = $urandom;
  endtask

  task automatic new_d();
    d_req  = 1'b1;
    d_we   = 1'($urandom_range(0, 1));
    d_addr = $urandom;
    d_wd   = $urandom;
    d_be   = 4'($urandom_range(0, 15));
  endtask

  task automatic finish_txn(input bit err);
    logic [31:0] v, old, mask;
    v = err ? 32'hDEADBEEF : rdmem(exp_addr);
    if (!err && exp_we) begin
      old  = rdmem(exp_addr);
      mask = {{8{exp_be[3]}}, {8{exp_be[2]}}, {8{exp_be[1]}}, {8{exp_be[0]}}};
      mem[exp_addr[31:2]] = (old & ~mask) | (exp_wd & mask);
    end
    ph      = M_DONE;
    exp_err = err;
    m_done++;
    if (err) m_errs++;
    if (own_d) begin
      if (!exp_we) m_d_rd = v;
    end else begin
      m_i_rd = v;
    end
  endtask

  // One clock: predict the edge from the driven inputs, observe, then react.
  task automatic cyc();
    if (reset) begin
      ph = M_IDLE; streak = 0; wcnt = 0; m_i_rd = '0; m_d_rd = '0;
    end else begin
      case (ph)
        M_IDLE: begin
          if (d_req && !(i_req && streak == MAXS)) begin
            own_d = 1'b1; exp_we = d_we; exp_addr = d_addr; exp_wd = d_wd;
            exp_be = d_we ? d_be : 4'hF;
            streak = i_req ? ((streak < MAXS) ? streak + 1 : streak) : 0;
            glog.push_back(1'b1); ph = M_WAIT; wcnt = 0;
            if (auto_mode) lat = $urandom_range(0, 3);
          end else if (i_req) begin
            own_d = 1'b0; exp_we = 1'b0; exp_addr = i_addr; exp_be = 4'hF;
            streak = 0; glog.push_back(1'b0); ph = M_WAIT; wcnt = 0;
            if (auto_mode) lat = $urandom_range(0, 3);
          end
        end
        M_WAIT: begin
          if (mem_ack) finish_txn(1'b0);
          else if (wcnt == TIMEOUT) finish_txn(1'b1);
          else wcnt++;
        end
        default: ph = M_IDLE;
      endcase
    end

    @(negedge clk);
    cyc_n++;
    if (mem_req === 1'b1) req_high++;
    if (i_ack === 1'b1) n_iack++;
    if (d_ack === 1'b1) n_dack++;
    if (bus_err === 1'b1) n_err++;

    case (ph)
      M_IDLE: begin
        chk("idle_mem_req", 32'(mem_req), 32'd0);
        chk("idle_acks", 32'({i_ack, d_ack, bus_err}), 32'd0);
      end
      M_WAIT: begin
        chk("wait_mem_req", 32'(mem_req), 32'd1);
        chk("wait_mem_addr", mem_addr, exp_addr);
        chk("wait_mem_we", 32'(mem_we), 32'(exp_we));
        chk("wait_mem_be", 32'(mem_be), 32'(exp_be));
        if (exp_we) chk("wait_mem_wd", mem_wd, exp_wd);
        chk("wait_acks", 32'({i_ack, d_ack, bus_err}), 32'd0);
      end
      default: begin
        chk("done_mem_req", 32'(mem_req), 32'd0);
        chk("done_i_ack", 32'(i_ack), 32'(!own_d));
        chk("done_d_ack", 32'(d_ack), 32'(own_d));
        chk("done_bus_err", 32'(bus_err), 32'(exp_err));
      end
    endcase
    chk("i_rd", i_rd, m_i_rd);
    chk("d_rd", d_rd, m_d_rd);

    mem_ack = 1'b0;
    mem_rd  = $urandom;
    if (!reset && ph == M_WAIT && lat >= 0 && wcnt == lat) begin
      mem_ack = 1'b1;
      if (!exp_we) mem_rd = rdmem(exp_addr);
    end
    if (ph == M_DONE) begin
      if (own_d) begin
        if (renew_mode || (auto_mode && $urandom_range(0, 1) == 1)) new_d();
        else d_req = 1'b0;
      end else begin
        if (renew_mode || (auto_mode && $urandom_range(0, 1) == 1)) new_i();
        else i_req = 1'b0;
      end
    end
    if (auto_mode) begin
      if (!i_req && $urandom_range(0, 3) == 0) new_i();
      if (!d_req && $urandom_range(0, 2) == 0) new_d();
    end
  endtask

  task automatic wait_ack(input bit side_d, input int budget, output int at);
    at = -1;
    for (int k = 0; k < budget; k++) begin
      cyc();
      if ((side_d ? d_ack : i_ack) === 1'b1) begin
        at = cyc_n;
        break;
      end
    end
    chk("ack_within_budget", 32'(at >= 0), 32'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && (i_req || d_req || ph != M_IDLE); k++) cyc();
    chk("drained", 32'({i_req, d_req}), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc_n);
    $fatal(1, "watchdog");
  end

  initial begin
    int at, n0, c0, g0, e0, rh0;
    reset = 1'b1; mem_ack = 1'b0; mem_rd = '0;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wd = '0; d_be = '0;

    // Reset with both requests pending; D must win right after release
    i_req = 1'b1; i_addr = 32'h0000_0040;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_3000; d_wd = 32'h0; d_be = 4'h0;
    lat = 2;
    repeat (3) cyc();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wd", mem_wd, 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_acks", 32'({i_ack, d_ack, bus_err}), 32'd0);
    chk("rst_i_rd", i_rd, 32'd0);
    chk("rst_d_rd", d_rd, 32'd0);
    reset = 1'b0;
    cyc();
    chk("rst_first_grant_req", 32'(mem_req), 32'd1);
    chk("rst_first_grant_addr", mem_addr, 32'h0000_3000);
    wait_ack(1'b1, 20, at);
    wait_ack(1'b0, 20, at);
    chk("rst_grant_order_d", 32'(glog[0]), 32'd1);
    chk("rst_grant_order_i", 32'(glog[1]), 32'd0);
    repeat (2) cyc();

    // Lone fetch, memory answers in the first WAIT cycle
    mem[30'h40] = 32'hE3A0_1005;
    lat = 0; i_req = 1'b1; i_addr = 32'h0000_0100;
    n0 = cyc_n;
    cyc();
    chk("fetch_addr", mem_addr, 32'h0000_0100);
    chk("fetch_we", 32'(mem_we), 32'd0);
    wait_ack(1'b0, 20, at);
    chk("fetch_ack_latency", 32'(at - n0), 32'd2);
    repeat (5) cyc();
    chk("fetch_rd_held", i_rd, 32'hE3A0_1005);

    // Partial store; d_rd must keep the earlier load value
    lat = 3; c0 = n_dack;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_2000; d_wd = 32'h1234_5678; d_be = 4'b0011;
    cyc();
    chk("store_we", 32'(mem_we), 32'd1);
    chk("store_be", 32'(mem_be), 32'h3);
    wait_ack(1'b1, 20, at);
    repeat (3) cyc();
    chk("store_one_ack", 32'(n_dack - c0), 32'd1);
    chk("store_d_rd_held", d_rd, rdmem(32'h0000_3000));

    // Both sides requesting continuously: D,D,D,D,I repeating
    lat = 1; g0 = glog.size();
    renew_mode = 1'b1; new_i(); new_d();
    for (int k = 0; k < 400 && glog.size() - g0 < 15; k++) cyc();
    renew_mode = 1'b0;
    chk("streak_grant_count", 32'(glog.size() - g0 >= 15), 32'd1);
    for (int k = 0; k < 15 && g0 + k < glog.size(); k++)
      chk("streak_pattern", 32'(glog[g0 + k]), (k % 5 == 4) ? 32'd0 : 32'd1);
    drain();

    // Memory never answers: error completion, then normal service resumes
    lat = -1; rh0 = req_high; e0 = n_err;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_4000;
    wait_ack(1'b1, 400, at);
    chk("timeout_bus_err", 32'(bus_err), 32'd1);
    chk("timeout_wait_cycles", 32'(req_high - rh0), 32'(TIMEOUT + 1));
    chk("timeout_d_rd", d_rd, 32'hDEADBEEF);
    repeat (2) cyc();
    lat = 1; i_req = 1'b1; i_addr = 32'h0000_0500;
    wait_ack(1'b0, 20, at);
    chk("after_timeout_no_err", 32'(bus_err), 32'd0);
    chk("after_timeout_err_pulses", 32'(n_err - e0), 32'd1);
    chk("after_timeout_i_rd", i_rd, rdmem(32'h0000_0500));
    repeat (2) cyc();

    // Reset in WAIT abandons the access
    lat = -1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_6000;
    repeat (4) cyc();
    chk("pre_rst_in_wait", 32'(mem_req), 32'd1);
    reset = 1'b1; d_req = 1'b0;
    cyc();
    chk("rst_wait_mem_req", 32'(mem_req), 32'd0);
    reset = 1'b0; c0 = n_dack;
    repeat (20) cyc();
    chk("rst_wait_no_ack", 32'(n_dack - c0), 32'd0);

    // Randomized traffic and latencies
    g0 = glog.size(); auto_mode = 1'b1;
    repeat (3000) cyc();
    auto_mode = 1'b0;
    drain();
    chk("random_completions", 32'(n_iack + n_dack), 32'(m_done));
    chk("random_err_pulses", 32'(n_err), 32'(m_errs));
    chk("random_had_grants", 32'(glog.size() - g0 > 100), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
